// File: rtl/drive_pkg.sv
// drive_pkg: shared drive-command width, stop value, command encoding and arbiter FSM states
package drive_pkg;
  localparam int CMD_W = 3;
  localparam int STOP_CMD = 0;
  typedef enum logic [CMD_W-1:0] {
    CMD_STOP   = 3'd0,
    CMD_FWD    = 3'd1,
    CMD_BACK   = 3'd2,
    CMD_LEFT   = 3'd3,
    CMD_RIGHT  = 3'd4,
    CMD_SPIN_L = 3'd5,
    CMD_SPIN_R = 3'd6,
    CMD_SLOW   = 3'd7
  } drive_cmd_t;
  typedef enum logic [1:0] {RUN, HOLD, ESTOP} arb_state_t;
endpackage

// File: rtl/src_fresh_timer.sv
// src_fresh_timer: per-source command latch with a freshness countdown reloaded on every strobe
module src_fresh_timer #(
  parameter int CMD_W = drive_pkg::CMD_W,
  parameter int STOP_CMD = drive_pkg::STOP_CMD,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [CMD_W-1:0] cmd_i,
  output logic [CMD_W-1:0] cmd_o,
  output logic             fresh_o
);
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [TW-1:0] timer_q, timer_d;
  assign cmd_d = valid_i ? cmd_i : cmd_q;
  assign timer_d = valid_i ? TW'(TIMEOUT_CYC) : (timer_q != '0 ? timer_q - TW'(1) : timer_q);
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cmd_q <= CMD_W'(STOP_CMD);
      timer_q <= '0;
    end else begin
      cmd_q <= cmd_d;
      timer_q <= timer_d;
    end
  end
  assign cmd_o = cmd_q;
  assign fresh_o = timer_q != '0;
endmodule

// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter: priority merge of drive-command sources with staleness, hold debounce, latched e-stop and a coalescing update stream
module drive_cmd_arbiter #(
  parameter int N_SRC = 3,
  parameter int CMD_W = drive_pkg::CMD_W,
  parameter int STOP_CMD = drive_pkg::STOP_CMD,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MIN_HOLD_CYC = 5_000_000,
  localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1,
  localparam int HW = MIN_HOLD_CYC > 0 ? $clog2(MIN_HOLD_CYC + 1) : 1
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*CMD_W-1:0] src_cmd,
  input  logic [N_SRC-1:0]       src_enable,
  input  logic                   estop,
  input  logic                   estop_clear,
  output logic [CMD_W-1:0]       drive_state,
  output logic [SW-1:0]          drive_src,
  output logic                   drive_active,
  output logic                   upd_valid,
  output logic [CMD_W-1:0]       upd_state,
  input  logic                   upd_ready,
  output logic                   estop_latched
);
  localparam logic [CMD_W-1:0] STOP_V = CMD_W'(STOP_CMD);
  logic [CMD_W-1:0] cmd_s [N_SRC];
  logic [N_SRC-1:0] fresh_s;
  logic cand_valid;
  logic [SW-1:0] cand_src;
  logic [CMD_W-1:0] cand_cmd;
  drive_pkg::arb_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CMD_W-1:0] drive_q, drive_d, upd_state_q, upd_state_d;
  logic [SW-1:0] src_q, src_d;
  logic active_q, active_d, upd_valid_q, upd_valid_d, estop_q, take, chg;
  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    src_fresh_timer #(
      .CMD_W(CMD_W),
      .STOP_CMD(STOP_CMD),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
      .clk_50(clk_50),
      .reset(reset),
      .valid_i(src_valid[s]),
      .cmd_i(src_cmd[s*CMD_W +: CMD_W]),
      .cmd_o(cmd_s[s]),
      .fresh_o(fresh_s[s])
    );
  end
  // scan from lowest priority upward so the lowest qualifying index wins
  always_comb begin
    cand_valid = 1'b0;
    cand_src = src_q;
    cand_cmd = STOP_V;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_enable[i] && fresh_s[i]) begin
        cand_valid = 1'b1;
        cand_src = SW'(i);
        cand_cmd = cmd_s[i];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    drive_d = drive_q;
    src_d = src_q;
    active_d = active_q;
    take = 1'b0;
    if (estop) begin
      state_d = drive_pkg::ESTOP;
      hold_d = '0;
      drive_d = STOP_V;
      active_d = 1'b0;
    end else if (state_q == drive_pkg::ESTOP) begin
      state_d = estop_clear ? drive_pkg::RUN : drive_pkg::ESTOP;
    end else begin
      // during hold only a stop or a same-command ownership change may pass
      take = state_q == drive_pkg::RUN || cand_cmd == STOP_V || cand_cmd == drive_q;
      if (state_q == drive_pkg::HOLD) begin
        hold_d = hold_q > HW'(1) ? hold_q - HW'(1) : '0;
        state_d = hold_q > HW'(1) ? drive_pkg::HOLD : drive_pkg::RUN;
      end
      if (take) begin
        drive_d = cand_cmd;
        src_d = cand_src;
        active_d = cand_valid;
      end
      if (state_q == drive_pkg::RUN && cand_cmd != drive_q) begin
        hold_d = HW'(MIN_HOLD_CYC);
        state_d = drive_pkg::HOLD;
      end
    end
  end
  // a change always lands in the payload; a same-cycle transfer took the old one
  assign chg = drive_d != drive_q;
  assign upd_valid_d = chg || (upd_valid_q && !upd_ready);
  assign upd_state_d = chg ? drive_d : upd_state_q;
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= drive_pkg::RUN;
      hold_q <= '0;
      drive_q <= STOP_V;
      src_q <= '0;
      active_q <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_state_q <= STOP_V;
      estop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      drive_q <= drive_d;
      src_q <= src_d;
      active_q <= active_d;
      upd_valid_q <= upd_valid_d;
      upd_state_q <= upd_state_d;
      estop_q <= state_d == drive_pkg::ESTOP;
    end
  end
  assign drive_state = drive_q;
  assign drive_src = src_q;
  assign drive_active = active_q;
  assign upd_valid = upd_valid_q;
  assign upd_state = upd_state_q;
  assign estop_latched = estop_q;
endmodule
